// File: rtl/watch_time_set_ctrl.sv
// Time-setting controller for the HH.MM.SS watch: button debounce, hour/min/sec edit FSM,
// auto-repeat stepping, edit timeout and blink timing for the display scan stage.
module watch_time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int HOLD_CYC     = 500,
  parameter int REPEAT_CYC   = 100,
  parameter int BLINK_HALF   = 500,
  parameter int TIMEOUT_CYC  = 30000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic [6:0] CUR_HOUR,
  input  logic [6:0] CUR_MIN,
  input  logic [6:0] CUR_SEC,
  output logic [6:0] SET_HOUR,
  output logic [6:0] SET_MIN,
  output logic [6:0] SET_SEC,
  output logic       LOAD,
  output logic       RUN_EN,
  output logic [1:0] EDIT_FIELD,
  output logic       BLINK
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int RP_W = $clog2(HOLD_CYC + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MS_MAX   = 7'd59;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_EDIT_H = 2'd1,
    S_EDIT_M = 2'd2,
    S_EDIT_S = 2'd3
  } state_t;

  function automatic logic [6:0] clamp_val(input logic [6:0] v, input logic [6:0] maxv);
    return (v > maxv) ? 7'd0 : v;
  endfunction

  function automatic logic [6:0] step_val(input logic [6:0] v, input logic [6:0] maxv,
                                          input logic up, input logic dn);
    if (up)
      return (v >= maxv) ? 7'd0 : v + 7'd1;
    if (dn)
      return (v == 7'd0 || v > maxv) ? maxv : v - 7'd1;
    return v;
  endfunction

  // Button index: 0 mode, 1 up, 2 down
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      rise_q, rise_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  assign btn_raw = {BTN_DOWN, BTN_UP, BTN_MODE};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]    = deb_q[i];
      rise_d[i]   = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  logic mode_ev, up_ev, dn_ev;
  logic held_alone, rpt_fire, step_up, step_dn, any_ev;
  logic [RP_W-1:0] rpt_q, rpt_d;

  assign mode_ev    = rise_q[0];
  assign up_ev      = rise_q[1];
  assign dn_ev      = rise_q[2];
  assign held_alone = deb_q[1] ^ deb_q[2];

  // Repeat counter is armed only by a fresh press of a lone button, so a button left
  // held after its partner is released never starts repeating.
  always_comb begin
    rpt_fire = 1'b0;
    rpt_d    = '0;
    if (held_alone) begin
      if (up_ev || dn_ev) begin
        rpt_d = RP_W'(1);
      end else if (rpt_q == RP_W'(HOLD_CYC)) begin
        rpt_fire = 1'b1;
        rpt_d    = RP_W'(HOLD_CYC - REPEAT_CYC + 1);
      end else if (rpt_q != '0) begin
        rpt_d = rpt_q + RP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) rpt_q <= '0;
    else         rpt_q <= rpt_d;
  end

  assign step_up = (up_ev & ~deb_q[2]) | (rpt_fire & deb_q[1]);
  assign step_dn = (dn_ev & ~deb_q[1]) | (rpt_fire & deb_q[2]);
  assign any_ev  = mode_ev | up_ev | dn_ev | rpt_fire;

  state_t          state_q;
  logic [6:0]      hour_q, min_q, sec_q;
  logic [6:0]      set_hour_q, set_min_q, set_sec_q;
  logic            load_q, run_en_q, blink_q;
  logic [1:0]      field_q;
  logic [BL_W-1:0] blink_cnt_q;
  logic [TO_W-1:0] idle_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= S_RUN;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      set_hour_q  <= '0;
      set_min_q   <= '0;
      set_sec_q   <= '0;
      load_q      <= 1'b0;
      run_en_q    <= 1'b1;
      field_q     <= 2'd0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      idle_q      <= '0;
    end else begin
      load_q <= 1'b0;
      if (state_q == S_RUN) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
        idle_q      <= '0;
        if (mode_ev) begin
          state_q  <= S_EDIT_H;
          field_q  <= 2'd1;
          run_en_q <= 1'b0;
          hour_q   <= clamp_val(CUR_HOUR, HOUR_MAX);
          min_q    <= clamp_val(CUR_MIN, MS_MAX);
          sec_q    <= clamp_val(CUR_SEC, MS_MAX);
        end
      end else if (mode_ev) begin
        idle_q      <= '0;
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
        case (state_q)
          S_EDIT_H: begin
            state_q <= S_EDIT_M;
            field_q <= 2'd2;
          end
          S_EDIT_M: begin
            state_q <= S_EDIT_S;
            field_q <= 2'd3;
          end
          default: begin
            state_q    <= S_RUN;
            field_q    <= 2'd0;
            run_en_q   <= 1'b1;
            load_q     <= 1'b1;
            set_hour_q <= hour_q;
            set_min_q  <= min_q;
            set_sec_q  <= sec_q;
          end
        endcase
      end else if (!any_ev && idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
        // Abandon the edit; the edit registers are recaptured on the next entry.
        state_q     <= S_RUN;
        field_q     <= 2'd0;
        run_en_q    <= 1'b1;
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
        idle_q      <= '0;
      end else begin
        idle_q <= any_ev ? '0 : idle_q + TO_W'(1);
        if (step_up || step_dn) begin
          blink_q     <= 1'b1;
          blink_cnt_q <= '0;
          case (state_q)
            S_EDIT_H: hour_q <= step_val(hour_q, HOUR_MAX, step_up, step_dn);
            S_EDIT_M: min_q  <= step_val(min_q, MS_MAX, step_up, step_dn);
            default:  sec_q  <= step_val(sec_q, MS_MAX, step_up, step_dn);
          endcase
        end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BL_W'(1);
        end
      end
    end
  end

  assign SET_HOUR   = set_hour_q;
  assign SET_MIN    = set_min_q;
  assign SET_SEC    = set_sec_q;
  assign LOAD       = load_q;
  assign RUN_EN     = run_en_q;
  assign EDIT_FIELD = field_q;
  assign BLINK      = blink_q;

endmodule

// File: tb/tb_watch_time_set_ctrl.sv
// Bench for watch_time_set_ctrl: directed scenarios plus randomized edit sessions
// checked against a time-arithmetic model of the button/edit behaviour.
module tb_watch_time_set_ctrl;

  localparam int HOLD   = 500;
  localparam int REPEAT = 100;
  localparam int TIMEOUT = 30000;
  localparam int BLINKH = 500;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_mode, btn_up, btn_down;
  logic [6:0] cur_hour, cur_min, cur_sec;
  logic [6:0] set_hour, set_min, set_sec;
  logic       load, run_en, blink;
  logic [1:0] edit_field;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int load_cnt = 0;
  int ld_h, ld_m, ld_s, ld_run;

  watch_time_set_ctrl dut (
    .CLK        (clk),
    .RESETN     (resetn),
    .BTN_MODE   (btn_mode),
    .BTN_UP     (btn_up),
    .BTN_DOWN   (btn_down),
    .CUR_HOUR   (cur_hour),
    .CUR_MIN    (cur_min),
    .CUR_SEC    (cur_sec),
    .SET_HOUR   (set_hour),
    .SET_MIN    (set_min),
    .SET_SEC    (set_sec),
    .LOAD       (load),
    .RUN_EN     (run_en),
    .EDIT_FIELD (edit_field),
    .BLINK      (blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (load === 1'b1) begin
      load_cnt++;
      ld_h   = int'(set_hour);
      ld_m   = int'(set_min);
      ld_s   = int'(set_sec);
      ld_run = int'(run_en);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // which: bit0 mode, bit1 up, bit2 down; held raw for len cycles then released and settled
  task automatic hold_btn(input int which, input int len);
    int c;
    c = cyc;
    btn_mode = which[0];
    btn_up   = which[1];
    btn_down = which[2];
    wait_until(c + len);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    wait_until(c + len + 40);
  endtask

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  // A raw hold of len cycles yields a debounced hold of len cycles: one step at the press,
  // then steps at HOLD, HOLD+REPEAT, ... cycles after the press while still held.
  function automatic int nsteps(input int len);
    int n;
    n = 1;
    for (int off = HOLD; off < len; off += REPEAT) n++;
    return n;
  endfunction

  function automatic int capture(input int v, input int maxv);
    return (v > maxv) ? 0 : v;
  endfunction

  int c0, entry, lc;
  int exp_f [3];
  int cur_v [3];
  int dir, len;

  initial begin
    resetn   = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    cur_hour = 7'd12;
    cur_min  = 7'd34;
    cur_sec  = 7'd56;
    repeat (5) @(posedge clk);
    #1;
    check("rst_load",   32'(load),       32'd0);
    check("rst_run_en", 32'(run_en),     32'd1);
    check("rst_field",  32'(edit_field), 32'd0);
    check("rst_blink",  32'(blink),      32'd1);
    check("rst_set_h",  32'(set_hour),   32'd0);
    check("rst_set_m",  32'(set_min),    32'd0);
    check("rst_set_s",  32'(set_sec),    32'd0);
    resetn = 1'b1;
    wait_until(cyc + 5);

    hold_btn(1, 10);
    wait_until(cyc + 20);
    check("glitch_field", 32'(edit_field), 32'd0);
    check("glitch_run",   32'(run_en),     32'd1);

    c0 = cyc;
    btn_mode = 1'b1;
    wait_until(c0 + 22);
    check("mode_lat_pre_field", 32'(edit_field), 32'd0);
    check("mode_lat_pre_run",   32'(run_en),     32'd1);
    wait_until(c0 + 23);
    check("mode_lat_field", 32'(edit_field), 32'd1);
    check("mode_lat_run",   32'(run_en),     32'd0);
    wait_until(c0 + 30);
    btn_mode = 1'b0;
    entry = c0 + 23;
    wait_until(entry + BLINKH / 2);
    check("blink_first_half", 32'(blink), 32'd1);
    wait_until(entry + BLINKH + BLINKH / 2);
    check("blink_second_half", 32'(blink), 32'd0);
    wait_until(entry + 2 * BLINKH + BLINKH / 2);
    check("blink_third_half", 32'(blink), 32'd1);
    lc = load_cnt;
    hold_btn(1, 30);
    hold_btn(1, 30);
    hold_btn(1, 30);
    check("noedit_loads", 32'(load_cnt - lc), 32'd1);
    check("noedit_set_h", 32'(set_hour), 32'd12);
    check("noedit_set_m", 32'(set_min),  32'd34);
    check("noedit_set_s", 32'(set_sec),  32'd56);

    cur_hour = 7'd23;
    cur_min  = 7'd59;
    cur_sec  = 7'd59;
    lc = load_cnt;
    hold_btn(1, 30);
    hold_btn(2, 30);
    hold_btn(1, 30);
    hold_btn(2, 30);
    hold_btn(1, 30);
    check("wrap_field_s", 32'(edit_field), 32'd3);
    hold_btn(4, 30);
    hold_btn(1, 30);
    check("wrap_loads",  32'(load_cnt - lc), 32'd1);
    check("wrap_ld_h",   32'(ld_h),   32'd0);
    check("wrap_ld_m",   32'(ld_m),   32'd0);
    check("wrap_ld_s",   32'(ld_s),   32'd58);
    check("wrap_ld_run", 32'(ld_run), 32'd1);

    cur_hour = 7'd5;
    cur_min  = 7'd10;
    cur_sec  = 7'd0;
    lc = load_cnt;
    hold_btn(1, 30);
    hold_btn(1, 30);
    hold_btn(2, 842);
    hold_btn(1, 30);
    hold_btn(1, 30);
    check("repeat_loads", 32'(load_cnt - lc), 32'd1);
    check("repeat_set_m", 32'(set_min),  32'(10 + nsteps(842)));
    check("repeat_set_h", 32'(set_hour), 32'd5);

    cur_hour = 7'd7;
    cur_min  = 7'd20;
    cur_sec  = 7'd30;
    lc = load_cnt;
    hold_btn(1, 30);
    hold_btn(3, 30);
    check("simul_field", 32'(edit_field), 32'd2);
    hold_btn(6, 700);
    hold_btn(1, 30);
    hold_btn(1, 30);
    check("simul_loads", 32'(load_cnt - lc), 32'd1);
    check("simul_set_h", 32'(set_hour), 32'd7);
    check("simul_set_m", 32'(set_min),  32'd20);
    check("simul_set_s", 32'(set_sec),  32'd30);

    for (int it = 0; it < 6; it++) begin
      cur_v[0] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(24, 127)) : int'($urandom_range(0, 23));
      cur_v[1] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 59));
      cur_v[2] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 59));
      cur_hour = 7'(cur_v[0]);
      cur_min  = 7'(cur_v[1]);
      cur_sec  = 7'(cur_v[2]);
      exp_f[0] = capture(cur_v[0], 23);
      exp_f[1] = capture(cur_v[1], 59);
      exp_f[2] = capture(cur_v[2], 59);
      lc = load_cnt;
      hold_btn(1, 30);
      for (int f = 0; f < 3; f++) begin
        dir = int'($urandom_range(0, 2));
        len = 100 * int'($urandom_range(0, 7)) + int'($urandom_range(30, 80));
        if (dir != 0) begin
          hold_btn((dir == 1) ? 2 : 4, len);
          exp_f[f] = wrap(exp_f[f] + ((dir == 1) ? 1 : -1) * nsteps(len), (f == 0) ? 24 : 60);
        end
        hold_btn(1, 30);
      end
      check("rand_loads", 32'(load_cnt - lc), 32'd1);
      check("rand_set_h", 32'(set_hour), 32'(exp_f[0]));
      check("rand_set_m", 32'(set_min),  32'(exp_f[1]));
      check("rand_set_s", 32'(set_sec),  32'(exp_f[2]));
    end

    cur_hour = 7'd1;
    cur_min  = 7'd2;
    cur_sec  = 7'd3;
    lc = load_cnt;
    c0 = cyc;
    hold_btn(1, 30);
    entry = c0 + 23;
    wait_until(entry + TIMEOUT - 10);
    check("timeout_pre_field", 32'(edit_field), 32'd1);
    check("timeout_pre_run",   32'(run_en),     32'd0);
    wait_until(entry + TIMEOUT + 10);
    check("timeout_field", 32'(edit_field), 32'd0);
    check("timeout_run",   32'(run_en),     32'd1);
    check("timeout_blink", 32'(blink),      32'd1);
    check("timeout_loads", 32'(load_cnt - lc), 32'd0);

    lc = load_cnt;
    hold_btn(1, 30);
    hold_btn(2, 30);
    check("midrst_pre_field", 32'(edit_field), 32'd1);
    resetn = 1'b0;
    wait_until(cyc + 3);
    check("midrst_field", 32'(edit_field), 32'd0);
    check("midrst_run",   32'(run_en),     32'd1);
    check("midrst_blink", 32'(blink),      32'd1);
    check("midrst_set_h", 32'(set_hour),   32'd0);
    check("midrst_set_m", 32'(set_min),    32'd0);
    check("midrst_set_s", 32'(set_sec),    32'd0);
    resetn = 1'b1;
    wait_until(cyc + 50);
    check("midrst_loads",      32'(load_cnt - lc), 32'd0);
    check("midrst_post_field", 32'(edit_field),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
